phase_loader: RTL and testbench
===============================

PHASE_LOADER -- requirements
Module: phase_loader

Interface
REQ-001 Parameter OFFSET_WIDTH, default 11, width of one channel offset word; the MSB is the initial output level and the low OFFSET_WIDTH-1 bits are the counter preload.
REQ-002 Parameter CHANNELS, default 16, number of transducer channels; the legal range is 1..64.
REQ-003 Parameter SYNC_LEN, default 4, number of cycles the resync pulse is held low; the legal range is 1..15.
REQ-004 Parameter DIVIDE_RESET, default 624, reset value of the divide word.
REQ-005 clk  in  1  system clock, 50 MHz.
REQ-006 rst  in  1  reset, synchronous and active-low, sampled on the rising edge of clk.
REQ-007 rx_data  in  8  command byte stream.
REQ-008 rx_valid  in  1  rx_data is valid.
REQ-009 rx_ready  out  1  the block accepts a byte this cycle; a transfer occurs when rx_valid and rx_ready are both high at a rising edge of clk.
REQ-010 offsets  out  CHANNELS*OFFSET_WIDTH  active offset bank, flattened; channel n occupies bits [n*OFFSET_WIDTH +: OFFSET_WIDTH].
REQ-011 divide  out  OFFSET_WIDTH-1  active divide word, shared by all channels.
REQ-012 oe_ch  out  CHANNELS  per-channel output enable, driven to the clock generators' first enable input.
REQ-013 oe_global  out  1  global output enable, driven to the clock generators' second enable input.
REQ-014 sync_n  out  1  active-low resync pulse; the system ANDs it with rst to drive the reset input of every clock generator.
REQ-015 err  out  1  sticky flag for a command addressed to an illegal channel.

Function
REQ-016 The opcode byte SHALL be decoded as op = rx_data[7:6] and ch = rx_data[5:0].
REQ-017 op 00 SET_OFFSET SHALL take two further bytes, MSB first, and write the low OFFSET_WIDTH bits of the 16-bit value to shadow offset[ch].
REQ-018 op 01 SET_DIVIDE SHALL take two further bytes, MSB first, and write the low OFFSET_WIDTH-1 bits to the shadow divide; ch is ignored.
REQ-019 op 10 SET_OE SHALL take one further byte and write its bit0 to oe_ch[ch] immediately, without shadowing.
REQ-020 op 11 APPLY SHALL take no further bytes; it sets oe_global = rx_data[0] and starts the resync sequence.
REQ-021 The FSM states SHALL be IDLE, DATA_HI, DATA_LO, OE_DATA and SYNC.
REQ-022 IDLE SHALL go to DATA_HI on op 00/01, to OE_DATA on op 10, and to SYNC on op 11.
REQ-023 DATA_HI SHALL go to DATA_LO, and both DATA_LO and OE_DATA SHALL return to IDLE, each on one accepted byte.
REQ-024 On the cycle an APPLY byte is accepted, the next edge SHALL copy all shadow offsets and the shadow divide into the active bank and drive sync_n low.
REQ-025 sync_n SHALL stay low for exactly SYNC_LEN cycles; the active bank SHALL be stable for that whole window.
REQ-026 In SYNC, rx_ready SHALL be 0; the FSM returns to IDLE on the same edge sync_n returns high.
REQ-027 In every other state, rx_ready SHALL be 1.
REQ-028 A command with ch >= CHANNELS SHALL consume its data bytes, discard the write, and set err; APPLY never sets err.
REQ-029 The active offsets and divide SHALL change only in response to APPLY; shadow writes SHALL never alter outputs.
REQ-030 When rx_valid is low mid-command, the FSM SHALL hold its state indefinitely; there is no timeout.
REQ-031 Two consecutive APPLY commands SHALL produce two separate pulses, with at least one cycle of sync_n high between them.

Reset
REQ-032 While rst is low at a rising edge, the block SHALL set: FSM to IDLE, rx_ready=0, all active and shadow offsets=0, active and shadow divide=DIVIDE_RESET, oe_ch=0, oe_global=0, sync_n=1, err=0.
REQ-033 A reset asserted mid-command or mid-pulse SHALL abort the operation and discard any partial data on the next edge.
REQ-034 rx_ready SHALL be 1 on the first edge after rst goes high.

Structure
REQ-035 A shared package SHALL hold the opcode constants (OP_SET_OFFSET, OP_SET_DIVIDE, OP_SET_OE, OP_APPLY), the FSM state encoding, and the default width constants.
REQ-036 The shadow/active register pair with its bulk copy SHALL be a sub-module named phase_bank; the FSM and pulse counter SHALL remain in phase_loader.

Verification
REQ-037 Sequence 0x03,0x04,0x71 then 0xC1: offset[3] stays 0 until APPLY, then reads 0x471; sync_n is low for exactly 4 cycles; oe_global=1; rx_ready is low during the pulse.
REQ-038 Sequence 0x40,0x01,0x37 then APPLY: divide becomes 0x137; there is no change before the APPLY.
REQ-039 Sequence 0x85,0x01 with CHANNELS=16: oe_ch[5]=1 on the edge after the second byte; sync_n stays 1.
REQ-040 Sequence 0x3F,0x12,0x34 with CHANNELS=16: err=1 and no offset changes; a following 0x00 is decoded as a new opcode.
REQ-041 Assert rst low during DATA_LO, or on the second cycle of sync_n low: all outputs return to the REQ-032 values; a following SET_OFFSET/APPLY sequence completes correctly.
REQ-042 Hold rx_valid low for 100 cycles between DATA_HI and DATA_LO: the command completes correctly once the last byte arrives.

Source files
------------

// File: rtl/phase_loader_pkg.sv
// Shared constants for the phase loader: default widths, command opcodes
// and the command-parser state encoding.
package phase_loader_pkg;

  localparam int OFFSET_WIDTH_DEF = 11;
  localparam int CHANNELS_DEF     = 16;
  localparam int SYNC_LEN_DEF     = 4;
  localparam int DIVIDE_RESET_DEF = 624;

  localparam logic [1:0] OP_SET_OFFSET = 2'b00;
  localparam logic [1:0] OP_SET_DIVIDE = 2'b01;
  localparam logic [1:0] OP_SET_OE     = 2'b10;
  localparam logic [1:0] OP_APPLY      = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DATA_HI = 3'd1,
    DATA_LO = 3'd2,
    OE_DATA = 3'd3,
    SYNC    = 3'd4
  } state_t;

endpackage

// File: rtl/phase_loader_if.sv
// Command byte stream into the phase loader.
// A byte transfers on a rising clk edge where rx_valid and rx_ready are both 1;
// the master holds rx_data stable while rx_valid is high and rx_ready is low.
interface phase_loader_if;

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);

endinterface

// File: rtl/phase_bank.sv
// Shadow/active offset and divide registers; apply copies the whole shadow
// bank into the active outputs in one edge.
module phase_bank
  import phase_loader_pkg::*;
#(
  parameter int OFFSET_WIDTH = OFFSET_WIDTH_DEF,
  parameter int CHANNELS     = CHANNELS_DEF,
  parameter int DIVIDE_RESET = DIVIDE_RESET_DEF
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             off_wr,
  input  logic [5:0]                       off_ch,
  input  logic [OFFSET_WIDTH-1:0]          off_data,
  input  logic                             div_wr,
  input  logic [OFFSET_WIDTH-2:0]          div_data,
  input  logic                             apply,
  output logic [CHANNELS*OFFSET_WIDTH-1:0] offsets,
  output logic [OFFSET_WIDTH-2:0]          divide
);

  localparam logic [OFFSET_WIDTH-2:0] DIV_INIT = (OFFSET_WIDTH-1)'(DIVIDE_RESET);

  logic [OFFSET_WIDTH-1:0] shadow_off [CHANNELS];
  logic [OFFSET_WIDTH-2:0] shadow_div;

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < CHANNELS; i++) begin
        shadow_off[i] <= '0;
      end
      shadow_div <= DIV_INIT;
      offsets    <= '0;
      divide     <= DIV_INIT;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (off_wr && off_ch == 6'(i)) begin
          shadow_off[i] <= off_data;
        end
      end
      if (div_wr) begin
        shadow_div <= div_data;
      end
      if (apply) begin
        for (int i = 0; i < CHANNELS; i++) begin
          offsets[i*OFFSET_WIDTH +: OFFSET_WIDTH] <= shadow_off[i];
        end
        divide <= shadow_div;
      end
    end
  end

endmodule

// File: rtl/phase_loader.sv
// Byte-command parser that loads per-channel phase offsets and the divide
// word, and on APPLY commits them together with an active-low resync pulse.
module phase_loader
  import phase_loader_pkg::*;
#(
  parameter int OFFSET_WIDTH = OFFSET_WIDTH_DEF,
  parameter int CHANNELS     = CHANNELS_DEF,
  parameter int SYNC_LEN     = SYNC_LEN_DEF,
  parameter int DIVIDE_RESET = DIVIDE_RESET_DEF
) (
  input  logic                             clk,
  input  logic                             rst,
  phase_loader_if.slave                    rx,
  output logic [CHANNELS*OFFSET_WIDTH-1:0] offsets,
  output logic [OFFSET_WIDTH-2:0]          divide,
  output logic [CHANNELS-1:0]              oe_ch,
  output logic                             oe_global,
  output logic                             sync_n,
  output logic                             err,
  output state_t                           state
);

  localparam logic [6:0] CH_LIMIT = 7'(CHANNELS);

  logic [1:0]  op_q;
  logic [5:0]  ch_q;
  logic [7:0]  hi_q;
  logic [3:0]  sync_cnt;
  logic        accept;
  logic        ch_ok;
  logic [15:0] word;
  logic        off_wr;
  logic        div_wr;
  logic        apply;

  // Bank strobes are decoded from the accepting edge so APPLY commits on the
  // same edge that drops sync_n.
  assign accept = rx.rx_valid && rx.rx_ready;
  assign ch_ok  = {1'b0, ch_q} < CH_LIMIT;
  assign word   = {hi_q, rx.rx_data};
  assign off_wr = accept && state == DATA_LO && op_q == OP_SET_OFFSET && ch_ok;
  assign div_wr = accept && state == DATA_LO && op_q == OP_SET_DIVIDE;
  assign apply  = accept && state == IDLE && rx.rx_data[7:6] == OP_APPLY;

  phase_bank #(
    .OFFSET_WIDTH (OFFSET_WIDTH),
    .CHANNELS     (CHANNELS),
    .DIVIDE_RESET (DIVIDE_RESET)
  ) u_bank (
    .clk      (clk),
    .rst      (rst),
    .off_wr   (off_wr),
    .off_ch   (ch_q),
    .off_data (word[OFFSET_WIDTH-1:0]),
    .div_wr   (div_wr),
    .div_data (word[OFFSET_WIDTH-2:0]),
    .apply    (apply),
    .offsets  (offsets),
    .divide   (divide)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      rx.rx_ready <= 1'b0;
      op_q        <= '0;
      ch_q        <= '0;
      hi_q        <= '0;
      sync_cnt    <= '0;
      oe_ch       <= '0;
      oe_global   <= 1'b0;
      sync_n      <= 1'b1;
      err         <= 1'b0;
    end else begin
      rx.rx_ready <= 1'b1;
      case (state)
        IDLE: begin
          if (accept) begin
            op_q <= rx.rx_data[7:6];
            ch_q <= rx.rx_data[5:0];
            case (rx.rx_data[7:6])
              OP_SET_OFFSET, OP_SET_DIVIDE: state <= DATA_HI;
              OP_SET_OE:                    state <= OE_DATA;
              default: begin
                state       <= SYNC;
                oe_global   <= rx.rx_data[0];
                sync_n      <= 1'b0;
                sync_cnt    <= 4'(SYNC_LEN - 1);
                rx.rx_ready <= 1'b0;
              end
            endcase
          end
        end
        DATA_HI: begin
          if (accept) begin
            hi_q  <= rx.rx_data;
            state <= DATA_LO;
          end
        end
        DATA_LO: begin
          if (accept) begin
            state <= IDLE;
            if (op_q == OP_SET_OFFSET && !ch_ok) begin
              err <= 1'b1;
            end
          end
        end
        OE_DATA: begin
          if (accept) begin
            state <= IDLE;
            if (!ch_ok) begin
              err <= 1'b1;
            end
            for (int i = 0; i < CHANNELS; i++) begin
              if (ch_ok && ch_q == 6'(i)) begin
                oe_ch[i] <= rx.rx_data[0];
              end
            end
          end
        end
        SYNC: begin
          // sync_n rises on the same edge the parser reopens for bytes.
          if (sync_cnt == 4'd0) begin
            sync_n <= 1'b1;
            state  <= IDLE;
          end else begin
            sync_cnt    <= sync_cnt - 4'd1;
            rx.rx_ready <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_phase_loader.sv
// Bench for phase_loader: directed command sequences plus random traffic,
// checked against a byte-level command model and an APPLY scoreboard.
module tb_phase_loader;
  import phase_loader_pkg::*;

  localparam int OW   = 11;
  localparam int NCH  = 16;
  localparam int SLEN = 4;
  localparam int DRST = 624;
  localparam int BW   = NCH*OW + (OW-1) + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;

  phase_loader_if rx ();

  logic [NCH*OW-1:0] offsets;
  logic [OW-2:0]     divide;
  logic [NCH-1:0]    oe_ch;
  logic              oe_global;
  logic              sync_n;
  logic              err;
  state_t            state;

  phase_loader #(
    .OFFSET_WIDTH (OW),
    .CHANNELS     (NCH),
    .SYNC_LEN     (SLEN),
    .DIVIDE_RESET (DRST)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .offsets   (offsets),
    .divide    (divide),
    .oe_ch     (oe_ch),
    .oe_global (oe_global),
    .sync_n    (sync_n),
    .err       (err),
    .state     (state)
  );

  always #10 clk = ~clk;

  // ---------------- reference model ----------------
  int   shadow_off [NCH];
  int   active_off [NCH];
  int   shadow_div;
  int   active_div;
  bit   m_oe [NCH];
  bit   m_oe_g;
  bit   m_err;
  int   stage;
  int   m_op;
  int   m_ch;
  logic [7:0] m_hi;

  logic [BW-1:0] exp_q [$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [BW-1:0] snapshot();
    logic [BW-1:0] s;
    s = '0;
    for (int i = 0; i < NCH; i++) s[i*OW +: OW] = OW'(active_off[i]);
    s[NCH*OW +: OW-1] = (OW-1)'(active_div);
    s[BW-1] = m_oe_g;
    return s;
  endfunction

  function automatic logic [NCH-1:0] model_oe();
    logic [NCH-1:0] v;
    for (int i = 0; i < NCH; i++) v[i] = m_oe[i];
    return v;
  endfunction

  function automatic logic [OW-1:0] off_of(input int ch);
    return offsets[ch*OW +: OW];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      shadow_off[i] = 0;
      active_off[i] = 0;
      m_oe[i] = 1'b0;
    end
    shadow_div = DRST;
    active_div = DRST;
    m_oe_g = 1'b0;
    m_err = 1'b0;
    stage = 0;
  endtask

  // stage: 0 expecting opcode, 1 expecting high byte, 2 low byte, 3 enable byte
  task automatic model_byte(input logic [7:0] b);
    int v;
    case (stage)
      0: begin
        m_op = int'(b[7:6]);
        m_ch = int'(b[5:0]);
        if (m_op == int'(OP_APPLY)) begin
          m_oe_g = b[0];
          for (int i = 0; i < NCH; i++) active_off[i] = shadow_off[i];
          active_div = shadow_div;
          exp_q.push_back(snapshot());
        end else if (m_op == int'(OP_SET_OE)) begin
          stage = 3;
        end else begin
          stage = 1;
        end
      end
      1: begin
        m_hi = b;
        stage = 2;
      end
      2: begin
        v = int'(m_hi) * 256 + int'(b);
        if (m_op == int'(OP_SET_OFFSET)) begin
          if (m_ch < NCH) shadow_off[m_ch] = v % (1 << OW);
          else m_err = 1'b1;
        end else begin
          shadow_div = v % (1 << (OW-1));
        end
        stage = 0;
      end
      default: begin
        if (m_ch < NCH) m_oe[m_ch] = b[0];
        else m_err = 1'b1;
        stage = 0;
      end
    endcase
  endtask

  // ---------------- driver tasks (called at negedge) ----------------
  task automatic send_byte(input logic [7:0] b);
    int budget;
    budget = 0;
    rx.rx_data  = b;
    rx.rx_valid = 1'b1;
    while (!rx.rx_ready && budget < 50) begin
      @(negedge clk);
      budget++;
    end
    if (!rx.rx_ready) begin
      total++;
      bad++;
      $display("FAIL ready_timeout: rx_ready=0 want 1 for byte %0h", b);
      rx.rx_valid = 1'b0;
      return;
    end
    model_byte(b);
    @(negedge clk);
    rx.rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b0;
    rx.rx_valid = 1'b0;
    model_reset();
    idle(cycles);
    rst = 1'b1;
    @(negedge clk);
    check("ready_after_rst", 256'(rx.rx_ready), 256'(1));
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    logic          prev_sync;
    bit            in_pulse;
    int            low_cnt;
    logic [BW-1:0] got;
    logic [BW-1:0] want;
    prev_sync = 1'b1;
    in_pulse  = 1'b0;
    low_cnt   = 0;
    forever begin
      @(posedge clk);
      #1;
      got = {oe_global, divide, offsets};
      if (!rst) begin
        check("rst_ready", 256'(rx.rx_ready), 256'(0));
        check("rst_sync_n", 256'(sync_n), 256'(1));
        check("rst_state", 256'(state), 256'(IDLE));
        in_pulse = 1'b0;
      end else if (prev_sync && !sync_n) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", 256'(sync_n), 256'(1));
        end else begin
          want = exp_q.pop_front();
          check("apply_bank", 256'(got), 256'(want));
        end
        check("pulse_ready", 256'(rx.rx_ready), 256'(0));
        in_pulse = 1'b1;
        low_cnt  = 1;
      end else if (in_pulse && !sync_n) begin
        check("pulse_ready", 256'(rx.rx_ready), 256'(0));
        low_cnt++;
      end else if (in_pulse && sync_n) begin
        check("pulse_len", 256'(low_cnt), 256'(SLEN));
        in_pulse = 1'b0;
      end
      check("bank", 256'(got), 256'(snapshot()));
      check("oe_ch", 256'(oe_ch), 256'(model_oe()));
      if (stage == 0) check("err", 256'(err), 256'(m_err));
      prev_sync = sync_n;
    end
  end

  initial begin : watchdog
    #1500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    int          op;
    logic [5:0]  ch;
    rx.rx_data  = 8'h00;
    rx.rx_valid = 1'b0;
    model_reset();
    idle(3);
    do_reset(0);

    // offset load, invisible until APPLY
    send_byte(8'h03); send_byte(8'h04); send_byte(8'h71);
    check("off3_before_apply", 256'(off_of(3)), 256'(0));
    send_byte(8'hC1);
    check("off3_after_apply", 256'(off_of(3)), 256'(11'h471));
    check("oe_global_set", 256'(oe_global), 256'(1));
    check("sync_low_at_apply", 256'(sync_n), 256'(0));
    idle(SLEN + 1);

    // divide load
    send_byte(8'h40); send_byte(8'h01); send_byte(8'h37);
    check("div_before_apply", 256'(divide), 256'(DRST));
    send_byte(8'hC0);
    check("div_after_apply", 256'(divide), 256'(10'h137));
    idle(SLEN + 1);

    // immediate output enable
    send_byte(8'h85); send_byte(8'h01);
    check("oe5_set", 256'(oe_ch[5]), 256'(1));
    check("oe_no_pulse", 256'(sync_n), 256'(1));

    // illegal channel, then a fresh opcode
    send_byte(8'h3F); send_byte(8'h12); send_byte(8'h34);
    check("err_set", 256'(err), 256'(1));
    send_byte(8'h00);
    check("new_opcode", 256'(state), 256'(DATA_HI));
    send_byte(8'h00); send_byte(8'h05);
    send_byte(8'hC1);
    check("off0_after_apply", 256'(off_of(0)), 256'(5));
    idle(SLEN + 1);

    // reset in DATA_LO
    send_byte(8'h02); send_byte(8'h01);
    check("in_data_lo", 256'(state), 256'(DATA_LO));
    do_reset(1);
    send_byte(8'h02); send_byte(8'h01); send_byte(8'h23); send_byte(8'hC1);
    check("off2_after_rst", 256'(off_of(2)), 256'(11'h123));
    idle(SLEN + 1);

    // reset on second low cycle of sync_n
    send_byte(8'h09); send_byte(8'h02); send_byte(8'h22);
    send_byte(8'hC1);
    @(negedge clk);
    check("mid_pulse_low", 256'(sync_n), 256'(0));
    do_reset(1);
    send_byte(8'h09); send_byte(8'h03); send_byte(8'h33); send_byte(8'hC0);
    check("off9_after_rst", 256'(off_of(9)), 256'(11'h333));
    idle(SLEN + 1);

    // long stall between high and low data bytes
    send_byte(8'h07); send_byte(8'h02);
    idle(100);
    check("stall_holds", 256'(state), 256'(DATA_LO));
    send_byte(8'h22); send_byte(8'hC1);
    check("off7_after_stall", 256'(off_of(7)), 256'(11'h222));
    idle(SLEN + 1);

    // back-to-back APPLY must give two pulses
    send_byte(8'hC0); send_byte(8'hC1);
    idle(SLEN + 2);

    // random traffic
    for (int n = 0; n < 250; n++) begin
      op = int'($urandom_range(0, 3));
      ch = ($urandom_range(0, 9) == 0) ? 6'd63 : 6'($urandom_range(0, 19));
      send_byte({2'(op), ch});
      if (op < 2) begin
        send_byte(8'($urandom));
        idle(int'($urandom_range(0, 2)));
        send_byte(8'($urandom));
      end else if (op == 2) begin
        send_byte(8'($urandom));
      end
      idle(int'($urandom_range(0, 2)));
    end

    idle(SLEN + 3);
    check("scoreboard_empty", 256'(exp_q.size()), 256'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
